serial_word_shifter: RTL

Parallel-to-serial stage that directly feeds the serial sequence-detector FSM.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits the word one bit per clock on x, which connects straight to the detector's x input, alongside a bit-valid strobe.
- Back-to-back words are supported with no idle gap, so patterns spanning word boundaries reach the detector intact.

---
 rtl/serial_word_shifter_pkg.sv | 14 +
 rtl/serial_word_shifter.sv | 93 +++++++++
 2 files changed

// File: rtl/serial_word_shifter_pkg.sv
// Shared definitions for the serial stages: FSM state encoding and counter sizing.
package serial_word_shifter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a WIDTH-bit word, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial shifter feeding the sequence detector: one bit per clock,
// gapless across back-to-back words, with a synchronous flush.
module serial_word_shifter
  import serial_word_shifter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             flush,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_adv;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             head_d;
  logic             last_bit;
  logic             accept;

  // Direction only changes which end is the head and which way the word advances.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_adv = {sh_q[WIDTH-2:0], 1'b0};
      assign head_d = sh_d[WIDTH-1];
    end else begin : g_lsb
      assign sh_adv = {1'b0, sh_q[WIDTH-1:1]};
      assign head_d = sh_d[0];
    end
  endgenerate

  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST);
  assign data_ready = !flush && ((state_q == ST_IDLE) || last_bit);
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      sh_d    = '0;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = ST_SHIFT;
      sh_d    = data_in;
      cnt_d   = '0;
    end else if (state_q == ST_SHIFT) begin
      sh_d = sh_adv;
      if (last_bit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // x is registered, so it is computed from the state being entered.
    x_d = (state_d == ST_SHIFT) ? head_d : IDLE_BIT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_BIT;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign x         = x_q;
  assign busy      = (state_q == ST_SHIFT);
  assign x_valid   = busy;
  assign word_done = last_bit;

endmodule
